melody_sequencer: RTL

- Upstream stage for the note-to-PWM mux. Plays a fixed song from an internal ROM and drives the mux's 4-bit note select.
- Each entry is held for a programmable number of beats, followed by a short silent gap (code 7) so that repeated notes articulate.
- Supports start, stop, loop and a done pulse.
- Timebase is a millisecond-style tick derived from the system clock.

---
 rtl/melody_sequencer_if.sv | 20 ++
 rtl/melody_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/melody_sequencer_if.sv
// Control and note-select bundle between the melody sequencer and its neighbours.
interface melody_sequencer_if;
    logic       start_i;
    logic       stop_i;
    logic       loop_i;
    logic [3:0] noteSelect_o;
    logic       playing_o;
    logic       done_o;
    logic [3:0] step_o;

    modport slave (
        input  start_i, stop_i, loop_i,
        output noteSelect_o, playing_o, done_o, step_o
    );

    modport master (
        output start_i, stop_i, loop_i,
        input  noteSelect_o, playing_o, done_o, step_o
    );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a fixed ROM song as note codes for the note-to-PWM mux; each entry is
// held for beats*BEAT_MS ticks, the last GAP_MS of which are silent.
module melody_sequencer #(
    parameter int CLK_FREQ = 100000000,
    parameter int TICK_HZ  = 1000,
    parameter int BEAT_MS  = 250,
    parameter int GAP_MS   = 20,
    parameter int SONG_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    melody_sequencer_if.slave bus
);
    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW       = $clog2(7 * BEAT_MS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NOTE,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic            done_q, done_d;

    logic            tick;
    logic [3:0]      step_n;
    logic [4:0]      nidx;
    logic            nxt_end;
    logic            first_end;
    logic [CW-1:0]   note_dur;

    function automatic logic [5:0] rom_word(input logic [3:0] idx);
        logic [5:0] w;
        case (idx)
            4'd0:    w = {3'd4, 3'd1};
            4'd1:    w = {3'd3, 3'd1};
            4'd2:    w = {3'd2, 3'd1};
            4'd3:    w = {3'd3, 3'd1};
            4'd4:    w = {3'd4, 3'd1};
            4'd5:    w = {3'd4, 3'd1};
            4'd6:    w = {3'd4, 3'd2};
            4'd7:    w = {3'd3, 3'd1};
            4'd8:    w = {3'd3, 3'd1};
            4'd9:    w = {3'd3, 3'd2};
            4'd10:   w = {3'd4, 3'd1};
            4'd11:   w = {3'd6, 3'd1};
            4'd12:   w = {3'd6, 3'd2};
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [2:0] beats_of(input logic [3:0] idx);
        logic [5:0] w;
        w = rom_word(idx);
        return w[2:0];
    endfunction

    function automatic logic [2:0] note_of(input logic [3:0] idx);
        logic [5:0] w;
        w = rom_word(idx);
        return w[5:3];
    endfunction

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign step_n    = step_q + 4'd1;
    assign nidx      = {1'b0, step_n};
    assign nxt_end   = (nidx >= 5'(SONG_LEN)) || (beats_of(step_n) == 3'd0);
    assign first_end = (beats_of(4'd0) == 3'd0);
    assign note_dur  = CW'(beats_of(step_q)) * CW'(BEAT_MS) - CW'(GAP_MS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            presc_q <= '0;
            tcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        presc_d = tick ? '0 : presc_q + PW'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (first_end) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_NOTE;
                        step_d  = '0;
                        tcnt_d  = '0;
                        presc_d = '0;
                    end
                end
            end
            ST_NOTE: begin
                if (tick) begin
                    if (tcnt_q == note_dur - CW'(1)) begin
                        state_d = ST_GAP;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (tcnt_q == CW'(GAP_MS - 1)) begin
                        tcnt_d = '0;
                        // The prescaler keeps running here so entries abut cycle-exactly.
                        if (!nxt_end) begin
                            state_d = ST_NOTE;
                            step_d  = step_n;
                        end else if (bus.loop_i) begin
                            state_d = ST_NOTE;
                            step_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                            step_d  = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.stop_i) begin
            state_d = ST_IDLE;
            step_d  = '0;
            tcnt_d  = '0;
            done_d  = 1'b0;
        end
    end

    assign bus.noteSelect_o = (state_q == ST_NOTE) ? {1'b0, note_of(step_q)} : 4'd7;
    assign bus.playing_o    = (state_q != ST_IDLE);
    assign bus.done_o       = done_q;
    assign bus.step_o       = step_q;
endmodule
